// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory slave with a valid/ready
// request channel, WAIT_CYCLES programmable wait states and a valid/ready
// response channel.
// Optional feature macro: DMEM_ERR_CHECK_EN enables misaligned and
// out-of-range fault detection; when it is undefined, addresses wrap modulo
// DEPTH_WORDS and rsp_error is always 0.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned LIMIT_B = DEPTH_WORDS * 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               write_q, write_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_error_q, rsp_error_d;
  logic               mem_we_c;
  logic               fault_c;
  logic [IDX_W-1:0]   idx_c;

  logic [31:0] mem [DEPTH_WORDS];

  assign idx_c = addr_q[IDX_W+1:2];

`ifdef DMEM_ERR_CHECK_EN
  // Fault on misaligned or beyond-array addresses.
  assign fault_c = (addr_q[1:0] != 2'b00) || (addr_q >= 32'(LIMIT_B));
`else
  // No fault detection; the byte offset and high address bits are dropped.
  logic unused_addr_bits;
  assign fault_c          = 1'b0;
  assign unused_addr_bits = ^{addr_q[1:0], addr_q[31:IDX_W+2]};
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Next-state and next-output logic for the IDLE/WAIT/RESP transaction.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    mem_we_c    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          write_d     = req_write;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          cnt_d       = CNT_W'(WAIT_CYCLES);
          req_ready_d = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          if (fault_c) begin
            rsp_error_d = 1'b1;
            rsp_rdata_d = '0;
          end else if (write_q) begin
            mem_we_c    = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            rsp_rdata_d = mem[idx_c];
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_error_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Storage array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[idx_c] <= wdata_q;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with WAIT_CYCLES=2,
// one with WAIT_CYCLES=0 for the throughput pattern.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        a_req_valid = 1'b0, a_req_write = 1'b0;
  logic [31:0] a_req_addr = '0, a_req_wdata = '0;
  logic        a_req_ready, a_rsp_valid, a_rsp_error;
  logic        a_rsp_ready = 1'b0;
  logic [31:0] a_rsp_rdata;

  logic        b_req_valid = 1'b0, b_req_write = 1'b0;
  logic [31:0] b_req_addr = '0, b_req_wdata = '0;
  logic        b_req_ready, b_rsp_valid, b_rsp_error;
  logic        b_rsp_ready = 1'b0;
  logic [31:0] b_rsp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_ready(a_req_ready),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_error(a_rsp_error)
  );

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_ready(b_req_ready),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_error(b_rsp_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction on dut_a; response held off for 'hold' cycles.
  task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata,
                     input logic exp_err, input int hold);
    int n;
    n = 0;
    while (!a_req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " req_ready before issue"}, 32'(a_req_ready), 32'd1);
    a_req_valid = 1'b1;
    a_req_write = wr;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    @(posedge clk); #1;
    // Perturb request inputs while the responder waits.
    a_req_valid = 1'b0;
    a_req_write = ~wr;
    a_req_addr  = 32'hFFFF_FFFC;
    a_req_wdata = 32'h5555_5555;
    n = 0;
    while (!a_rsp_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " latency"}, 32'(n), 32'd3);
    check({tag, " rdata"}, a_rsp_rdata, exp_rdata);
    check({tag, " error"}, 32'(a_rsp_error), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold valid"}, 32'(a_rsp_valid), 32'd1);
      check({tag, " hold rdata"}, a_rsp_rdata, exp_rdata);
      check({tag, " hold req_ready"}, 32'(a_req_ready), 32'd0);
    end
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
    check({tag, " post valid"}, 32'(a_rsp_valid), 32'd0);
    check({tag, " post req_ready"}, 32'(a_req_ready), 32'd1);
    check({tag, " post rdata"}, a_rsp_rdata, 32'd0);
  endtask

  initial begin
    // Reset values.
    #2 rst_n = 1'b0;
    #1;
    check("rst a req_ready", 32'(a_req_ready), 32'd1);
    check("rst a rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst a rsp_rdata", a_rsp_rdata, 32'd0);
    check("rst a rsp_error", 32'(a_rsp_error), 32'd0);
    check("rst b req_ready", 32'(b_req_ready), 32'd1);
    check("rst b rsp_valid", 32'(b_rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Round trip and backpressure.
    txn("st 0x10", 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
    txn("ld 0x10", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
    txn("ld bp 0x10", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 4);
    txn("st 0x00", 1'b1, 32'h00, 32'h0BAD_F00D, 32'h0, 1'b0, 0);
    txn("ld 0x00", 1'b0, 32'h00, 32'h0, 32'h0BAD_F00D, 1'b0, 0);

`ifdef DMEM_ERR_CHECK_EN
    // Faulted stores leave the array unchanged.
    txn("st misalign", 1'b1, 32'h13, 32'h1234_5678, 32'h0, 1'b1, 0);
    txn("st range", 1'b1, 32'h100, 32'h1234_5678, 32'h0, 1'b1, 0);
    txn("ld w4 after fault", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
    txn("ld w0 after fault", 1'b0, 32'h00, 32'h0, 32'h0BAD_F00D, 1'b0, 0);
`else
    // Out-of-range address wraps onto word 0.
    txn("st wrap 0x100", 1'b1, 32'h100, 32'hA5A5_A5A5, 32'h0, 1'b0, 0);
    txn("ld wrap 0x0", 1'b0, 32'h00, 32'h0, 32'hA5A5_A5A5, 1'b0, 0);
    txn("ld w4 after wrap", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
`endif

    // Reset during WAIT aborts the store.
    txn("st 0x20", 1'b1, 32'h20, 32'h1111_1111, 32'h0, 1'b0, 0);
    a_req_valid = 1'b1;
    a_req_write = 1'b1;
    a_req_addr  = 32'h20;
    a_req_wdata = 32'h2222_2222;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    check("mid accepted", 32'(a_req_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid rst req_ready", 32'(a_req_ready), 32'd1);
    check("mid rst rsp_valid", 32'(a_rsp_valid), 32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid idle rsp_valid", 32'(a_rsp_valid), 32'd0);
    txn("ld 0x20 after rst", 1'b0, 32'h20, 32'h0, 32'h1111_1111, 1'b0, 0);

    // Zero wait states: one transaction every 3 cycles.
    b_req_valid = 1'b1;
    b_req_write = 1'b1;
    b_req_addr  = 32'h0C;
    b_req_wdata = 32'hCAFE_0001;
    b_rsp_ready = 1'b1;
    @(posedge clk); #1;
    b_req_write = 1'b0;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("zw valid k%0d", k), 32'(b_rsp_valid), 32'((k % 3) == 1));
      check($sformatf("zw req_ready k%0d", k), 32'(b_req_ready), 32'((k % 3) == 2));
      if ((k % 3) == 1) begin
        check($sformatf("zw rdata k%0d", k), b_rsp_rdata, (k == 1) ? 32'h0 : 32'hCAFE_0001);
        check($sformatf("zw error k%0d", k), 32'(b_rsp_error), 32'd0);
      end
      @(posedge clk); #1;
    end
    b_req_valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
